// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter
// Description : Arbitrates N_PORTS load/store requesters onto one word-wide
//               memory bus. Handles byte-lane enables, store replication,
//               load alignment/extension and misalignment errors.
//               Optional macro ARB_ROUND_ROBIN_EN selects round-robin
//               arbitration; without it the lowest requesting index wins.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
    parameter int N_PORTS = 2,
    parameter int XLEN    = 32
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [N_PORTS-1:0]      i_req,
    input  logic [N_PORTS-1:0]      i_wen,
    input  logic [3*N_PORTS-1:0]    i_f3,
    input  logic [XLEN*N_PORTS-1:0] i_addr,
    input  logic [XLEN*N_PORTS-1:0] i_wdata,
    output logic [N_PORTS-1:0]      o_ready,
    output logic [N_PORTS-1:0]      o_err,
    output logic [XLEN*N_PORTS-1:0] o_rdata,
    output logic                    o_valid,
    output logic                    o_wr_en,
    output logic [XLEN-1:0]         o_addr,
    output logic [XLEN-1:0]         o_wr_data,
    output logic [3:0]              o_byte_en,
    input  logic                    i_ack,
    input  logic [XLEN-1:0]         i_rd_data
);

    localparam int IDXW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                    r_state, w_state_nxt;
    logic [IDXW-1:0]           r_grant, w_grant_nxt;
    logic [2:0]                r_f3, w_f3_nxt;
    logic [1:0]                r_off, w_off_nxt;

    logic [N_PORTS-1:0]        w_ready_nxt, w_err_nxt;
    logic [XLEN*N_PORTS-1:0]   w_rdata_nxt;
    logic                      w_valid_nxt, w_wr_en_nxt;
    logic [XLEN-1:0]           w_addr_nxt, w_wr_data_nxt;
    logic [3:0]                w_byte_en_nxt;

    logic [IDXW-1:0]           w_win;
    logic [2:0]                w_win_f3;
    logic [XLEN-1:0]           w_win_addr, w_win_wdata;
    logic                      w_win_wen, w_win_bad;

    // Align the bus word down to the accessed lane and sign/zero-extend.
    function automatic logic [XLEN-1:0] load_fmt(input logic [XLEN-1:0] d,
                                                 input logic [2:0] f3,
                                                 input logic [1:0] off);
        logic [XLEN-1:0] s;
        s = d >> {off, 3'b000};
        case (f3[1:0])
            2'b00:   load_fmt = f3[2] ? {{(XLEN-8){1'b0}}, s[7:0]}
                                      : {{(XLEN-8){s[7]}}, s[7:0]};
            2'b01:   load_fmt = f3[2] ? {{(XLEN-16){1'b0}}, s[15:0]}
                                      : {{(XLEN-16){s[15]}}, s[15:0]};
            default: load_fmt = s;
        endcase
    endfunction

    // Replicate right-aligned store data so every lane carries it.
    function automatic logic [XLEN-1:0] store_fmt(input logic [XLEN-1:0] w,
                                                  input logic [1:0] sz);
        case (sz)
            2'b00:   store_fmt = {(XLEN/8){w[7:0]}};
            2'b01:   store_fmt = {(XLEN/16){w[15:0]}};
            default: store_fmt = w;
        endcase
    endfunction

    // Byte-lane mask for the access size and low address bits.
    function automatic logic [3:0] lane_mask(input logic [1:0] sz,
                                             input logic [1:0] a);
        case (sz)
            2'b00:   lane_mask = 4'b0001 << a;
            2'b01:   lane_mask = 4'b0011 << {a[1], 1'b0};
            default: lane_mask = 4'b1111;
        endcase
    endfunction

`ifdef ARB_ROUND_ROBIN_EN
    logic [IDXW-1:0] r_ptr, w_ptr_nxt;

    // Round-robin pick: first requester after the last granted index.
    always_comb begin
        logic found;
        int   idx;
        w_win = '0;
        found = 1'b0;
        for (int k = 1; k <= N_PORTS; k++) begin
            idx = (int'(r_ptr) + k) % N_PORTS;
            if (!found && i_req[idx]) begin
                w_win = IDXW'(idx);
                found = 1'b1;
            end
        end
    end

    // Pointer register; reset so that port 0 is favoured first.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_ptr <= IDXW'(N_PORTS - 1);
        else       r_ptr <= w_ptr_nxt;
    end
`else
    // Fixed priority pick: lowest requesting index wins.
    always_comb begin
        w_win = '0;
        for (int k = N_PORTS - 1; k >= 0; k--) begin
            if (i_req[k]) w_win = IDXW'(k);
        end
    end
`endif

    // Fields of the winning request and its legality.
    always_comb begin
        w_win_wen   = i_wen[w_win];
        w_win_f3    = i_f3[w_win*3 +: 3];
        w_win_addr  = i_addr[w_win*XLEN +: XLEN];
        w_win_wdata = i_wdata[w_win*XLEN +: XLEN];
        w_win_bad   = (w_win_f3[1:0] == 2'b11) ||
                      ((w_win_f3[1:0] == 2'b01) && w_win_addr[0]) ||
                      ((w_win_f3[1:0] == 2'b10) && (w_win_addr[1:0] != 2'b00));
    end

    // Next-state and next-output logic; outputs hold unless changed.
    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_f3_nxt      = r_f3;
        w_off_nxt     = r_off;
        w_ready_nxt   = '0;
        w_err_nxt     = o_err;
        w_rdata_nxt   = o_rdata;
        w_valid_nxt   = o_valid;
        w_wr_en_nxt   = o_wr_en;
        w_addr_nxt    = o_addr;
        w_wr_data_nxt = o_wr_data;
        w_byte_en_nxt = o_byte_en;
`ifdef ARB_ROUND_ROBIN_EN
        w_ptr_nxt     = r_ptr;
`endif
        case (r_state)
            S_IDLE: begin
                if (|i_req) begin
                    w_grant_nxt = w_win;
                    w_f3_nxt    = w_win_f3;
                    w_off_nxt   = w_win_addr[1:0];
`ifdef ARB_ROUND_ROBIN_EN
                    w_ptr_nxt   = w_win;
`endif
                    if (w_win_bad) begin
                        // Illegal access completes without touching the bus.
                        w_state_nxt                     = S_RESP;
                        w_ready_nxt[w_win]              = 1'b1;
                        w_err_nxt[w_win]                = 1'b1;
                        w_rdata_nxt[w_win*XLEN +: XLEN] = '0;
                    end else begin
                        w_state_nxt   = S_BUSY;
                        w_valid_nxt   = 1'b1;
                        w_wr_en_nxt   = w_win_wen;
                        w_addr_nxt    = {w_win_addr[XLEN-1:2], 2'b00};
                        w_wr_data_nxt = store_fmt(w_win_wdata, w_win_f3[1:0]);
                        w_byte_en_nxt = lane_mask(w_win_f3[1:0], w_win_addr[1:0]);
                    end
                end
            end
            S_BUSY: begin
                if (i_ack) begin
                    w_state_nxt                       = S_RESP;
                    w_valid_nxt                       = 1'b0;
                    w_wr_en_nxt                       = 1'b0;
                    w_ready_nxt[r_grant]              = 1'b1;
                    w_err_nxt[r_grant]                = 1'b0;
                    w_rdata_nxt[r_grant*XLEN +: XLEN] = load_fmt(i_rd_data, r_f3, r_off);
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_valid_nxt = 1'b0;
                w_wr_en_nxt = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset abandons any bus transaction.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_grant   <= '0;
            r_f3      <= '0;
            r_off     <= '0;
            o_ready   <= '0;
            o_err     <= '0;
            o_rdata   <= '0;
            o_valid   <= 1'b0;
            o_wr_en   <= 1'b0;
            o_addr    <= '0;
            o_wr_data <= '0;
            o_byte_en <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_f3      <= w_f3_nxt;
            r_off     <= w_off_nxt;
            o_ready   <= w_ready_nxt;
            o_err     <= w_err_nxt;
            o_rdata   <= w_rdata_nxt;
            o_valid   <= w_valid_nxt;
            o_wr_en   <= w_wr_en_nxt;
            o_addr    <= w_addr_nxt;
            o_wr_data <= w_wr_data_nxt;
            o_byte_en <= w_byte_en_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_bus_arbiter
// Description : Scoreboard bench for mem_bus_arbiter. Stimulus pushes the
//               expected bus cycle and port response; monitors pop and check.
//               Expected grant order follows ARB_ROUND_ROBIN_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

    localparam int NP = 2;
    localparam int XL = 32;

    logic            i_clk = 1'b0;
    logic            i_rst = 1'b1;
    logic [NP-1:0]   i_req = '0;
    logic [NP-1:0]   i_wen = '0;
    logic [3*NP-1:0] i_f3 = '0;
    logic [XL*NP-1:0] i_addr = '0;
    logic [XL*NP-1:0] i_wdata = '0;
    logic [NP-1:0]   o_ready, o_err;
    logic [XL*NP-1:0] o_rdata;
    logic            o_valid, o_wr_en;
    logic [XL-1:0]   o_addr, o_wr_data;
    logic [3:0]      o_byte_en;
    logic            i_ack = 1'b0;
    logic [XL-1:0]   i_rd_data = '0;

    typedef struct packed {
        logic [7:0]  port;
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } bus_t;

    rsp_t rsp_q[$];
    bus_t bus_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic prev_valid = 1'b0;
    rsp_t mr;
    bus_t mb;

    mem_bus_arbiter #(.N_PORTS(NP), .XLEN(XL)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_wen(i_wen),
        .i_f3(i_f3), .i_addr(i_addr), .i_wdata(i_wdata),
        .o_ready(o_ready), .o_err(o_err), .o_rdata(o_rdata),
        .o_valid(o_valid), .o_wr_en(o_wr_en), .o_addr(o_addr),
        .o_wr_data(o_wr_data), .o_byte_en(o_byte_en),
        .i_ack(i_ack), .i_rd_data(i_rd_data)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Bus monitor: each new bus cycle must match the oldest expectation.
    always @(negedge i_clk) begin
        if (!i_rst && o_valid && !prev_valid) begin
            if (bus_q.size() == 0) begin
                chk("unexpected_bus_cycle", o_valid, 1'b0);
            end else begin
                mb = bus_q.pop_front();
                chk("bus_wr_en", o_wr_en, mb.wr);
                chk("bus_addr", o_addr, mb.addr);
                chk("bus_wdata", o_wr_data, mb.wdata);
                chk("bus_byte_en", o_byte_en, mb.be);
            end
        end
        prev_valid = o_valid;
    end

    // Response monitor: each ready pulse must match the oldest expectation.
    always @(negedge i_clk) begin
        if (!i_rst && (|o_ready)) begin
            if (rsp_q.size() == 0) begin
                chk("unexpected_ready", o_ready, 0);
            end else begin
                mr = rsp_q.pop_front();
                chk("ready_vec", o_ready, 64'(1) << mr.port);
                chk("err", o_err[mr.port], mr.err);
                chk("rdata", o_rdata[mr.port*XL +: XL], mr.rdata);
            end
        end
    end

    task automatic do_reset();
        @(negedge i_clk);
        i_rst = 1'b1;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
    endtask

    // Issue one request, play the bus slave, release the request on completion.
    task automatic run_txn(input int p, input logic wen, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rd, input int dly,
                           input logic exp_err, input logic [31:0] exp_rdata,
                           input logic [31:0] exp_baddr, input logic [3:0] exp_be,
                           input logic [31:0] exp_wdata);
        rsp_t r;
        bus_t b;
        r.port = 8'(p); r.err = exp_err; r.rdata = exp_rdata;
        rsp_q.push_back(r);
        if (!exp_err) begin
            b.wr = wen; b.addr = exp_baddr; b.wdata = exp_wdata; b.be = exp_be;
            bus_q.push_back(b);
        end
        @(posedge i_clk); #1;
        i_wen[p]           = wen;
        i_f3[p*3 +: 3]     = f3;
        i_addr[p*XL +: XL] = addr;
        i_wdata[p*XL +: XL] = wdata;
        i_req[p]           = 1'b1;
        if (!exp_err) begin
            for (int i = 0; i < 50 && !o_valid; i++) begin
                @(posedge i_clk); #1;
            end
            chk("wait_valid", o_valid, 1'b1);
            repeat (dly - 1) @(posedge i_clk);
            #1;
            i_ack = 1'b1;
            i_rd_data = rd;
            @(posedge i_clk); #1;
            i_ack = 1'b0;
        end else begin
            @(posedge i_clk); #1;
        end
        chk("ready_latency", o_ready[p], 1'b1);
        for (int i = 0; i < 50 && !o_ready[p]; i++) begin
            @(posedge i_clk); #1;
        end
        @(posedge i_clk); #1;
        i_req[p] = 1'b0;
    endtask

    initial begin
        int cnt;
        rsp_t r;
        bus_t b;

        // Reset values while reset is held.
        repeat (2) @(negedge i_clk);
        chk("rst_valid", o_valid, 0);
        chk("rst_wr_en", o_wr_en, 0);
        chk("rst_addr", o_addr, 0);
        chk("rst_byte_en", o_byte_en, 0);
        chk("rst_ready", o_ready, 0);
        chk("rst_rdata", o_rdata, 0);
        i_rst = 1'b0;

        //      port wen f3     addr        wdata        rd           dly err rdata        baddr        be       bus wdata
        run_txn(0, 0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 3, 0, 32'hDEADBEEF, 32'h100, 4'b1111, 32'h0);
        run_txn(1, 0, 3'b000, 32'h103, 32'h0,        32'h80AABBCC, 1, 0, 32'hFFFFFF80, 32'h100, 4'b1000, 32'h0);
        run_txn(1, 0, 3'b100, 32'h103, 32'h0,        32'h80AABBCC, 2, 0, 32'h00000080, 32'h100, 4'b1000, 32'h0);
        run_txn(1, 1, 3'b001, 32'h202, 32'h00001234, 32'h0,        1, 0, 32'h0,        32'h200, 4'b1100, 32'h12341234);
        run_txn(0, 0, 3'b010, 32'h101, 32'h0,        32'h0,        1, 1, 32'h0,        32'h0,   4'b0000, 32'h0);
        run_txn(1, 0, 3'b001, 32'h106, 32'h0,        32'h80011234, 1, 0, 32'hFFFF8001, 32'h104, 4'b1100, 32'h0);
        run_txn(0, 0, 3'b101, 32'h102, 32'h0,        32'h80011234, 2, 0, 32'h00008001, 32'h100, 4'b1100, 32'h0);
        run_txn(0, 1, 3'b000, 32'h005, 32'h000000A5, 32'h0,        1, 0, 32'h0,        32'h004, 4'b0010, 32'hA5A5A5A5);
        run_txn(1, 0, 3'b011, 32'h000, 32'h0,        32'h0,        1, 1, 32'h0,        32'h0,   4'b0000, 32'h0);
        run_txn(0, 0, 3'b001, 32'h101, 32'h0,        32'h0,        1, 1, 32'h0,        32'h0,   4'b0000, 32'h0);
        run_txn(0, 0, 3'b000, 32'h101, 32'h0,        32'h00007F00, 1, 0, 32'h0000007F, 32'h100, 4'b0010, 32'h0);

        // Both ports requesting continuously with immediate acks.
        do_reset();
        for (int g = 0; g < 4; g++) begin
`ifdef ARB_ROUND_ROBIN_EN
            r.port = 8'(g % 2);
`else
            r.port = 8'd0;
`endif
            r.err = 1'b0; r.rdata = 32'h11223344;
            rsp_q.push_back(r);
            b.wr = 1'b0; b.wdata = 32'h0; b.be = 4'b1111;
            b.addr = (r.port == 8'd0) ? 32'h10 : 32'h20;
            bus_q.push_back(b);
        end
        @(posedge i_clk); #1;
        i_wen = '0;
        i_f3 = {3'b010, 3'b010};
        i_addr = {32'h20, 32'h10};
        i_wdata = '0;
        i_rd_data = 32'h11223344;
        i_ack = 1'b1;
        i_req = 2'b11;
        cnt = 0;
        for (int i = 0; i < 60 && cnt < 4; i++) begin
            @(posedge i_clk); #1;
            if (|o_ready) cnt++;
        end
        @(posedge i_clk); #1;
        i_req = '0;
        i_ack = 1'b0;
        chk("arb_grant_count", cnt, 4);
        repeat (3) @(posedge i_clk);

        // Reset asserted in the middle of a bus transaction.
        b.wr = 1'b0; b.addr = 32'h300; b.wdata = 32'h0; b.be = 4'b1111;
        bus_q.push_back(b);
        @(posedge i_clk); #1;
        i_f3[2:0] = 3'b010;
        i_addr[31:0] = 32'h300;
        i_req[0] = 1'b1;
        for (int i = 0; i < 50 && !o_valid; i++) begin
            @(posedge i_clk); #1;
        end
        chk("abort_wait_valid", o_valid, 1'b1);
        @(negedge i_clk); #2;
        i_rst = 1'b1;
        #1;
        chk("abort_valid", o_valid, 0);
        chk("abort_wr_en", o_wr_en, 0);
        chk("abort_addr", o_addr, 0);
        chk("abort_wr_data", o_wr_data, 0);
        chk("abort_byte_en", o_byte_en, 0);
        chk("abort_ready", o_ready, 0);
        chk("abort_err", o_err, 0);
        chk("abort_rdata", o_rdata, 0);
        i_req = '0;
        @(negedge i_clk);
        i_rst = 1'b0;
        @(posedge i_clk); #1;
        i_ack = 1'b1;
        i_rd_data = 32'hCAFEF00D;
        @(posedge i_clk); #1;
        i_ack = 1'b0;
        repeat (5) @(posedge i_clk);
        #1;
        chk("abort_no_ready", o_ready, 0);
        chk("abort_no_valid", o_valid, 0);

        chk("rsp_queue_drained", rsp_q.size(), 0);
        chk("bus_queue_drained", bus_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "time limit exceeded");
    end

endmodule
`default_nettype wire
